mips_mc_ctrl: RTL and testbench
===============================

// Module: mips_mc_ctrl
// PURPOSE
//   Multi-cycle control FSM for the MIPS datapath (single shared instr/data memory, IR, PC, GRF, ALU).
//   Sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath selects and write strobes.
//   Handshakes with a variable-latency memory and counts retired instructions.
//   Sits inside mips, beside the datapath; op/funct/zero come from the datapath.
// PARAMETERS
//   CNT_W     32  width of retired-instruction counter
//   MAX_WAIT  15  max cycles a memory request may wait for mem_ready before ERR
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   op         in   6      IR[31:26], valid from DECODE onward
//   funct      in   6      IR[5:0]
//   zero       in   1      ALU equality flag (beq)
//   mem_ready  in   1      memory completes the current request this cycle
//   mem_req    out  1      memory request valid
//   mem_we     out  1      memory write (sw), only with mem_req
//   iord       out  1      address select: 0=PC, 1=ALU result
//   ir_we      out  1      load IR
//   pc_we      out  1      load PC
//   pc_src     out  2      00=PC+4, 01=branch target, 10=jump target, 11=GPR[rs]
//   reg_we     out  1      GRF write enable
//   reg_dst    out  2      00=rt, 01=rd, 10=$31
//   wd_src     out  2      00=ALU, 01=mem data, 10=PC (already incremented)
//   alu_src    out  1      0=GPR[rt], 1=extended imm
//   alu_op     out  3      000=add, 001=sub, 010=or, 011=lui (imm<<16)
//   ext_op     out  1      0=zero-ext, 1=sign-ext
//   state      out  3      current state (debug)
//   err        out  1      sticky memory-timeout flag
//   instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//   States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERR=7. All outputs are combinational on state/op/funct/zero/mem_ready.
//   Reset (reset=0, async): state=FETCH, instr_cnt=0, err=0, wait_cnt=0. While reset=0, all strobes and mem_req=0.
//   Instr set: addu(0/21h) subu(0/23h) jr(0/08h) ori(0Dh) lui(0Fh) lw(23h) sw(2Bh) beq(04h) j(02h) jal(03h).
//   FETCH: mem_req=1 iord=0. Cycle with mem_ready=1: ir_we=1, pc_we=1, pc_src=00 -> DECODE. Else stay.
//   DECODE (1 cycle): j: pc_we, pc_src=10 -> FETCH. jal: same + reg_we, reg_dst=10, wd_src=10 -> FETCH.
//     jr: pc_we, pc_src=11 -> FETCH. Other legal ops -> EXEC. Illegal op/funct: no strobes -> FETCH, not counted.
//   EXEC (1 cycle): addu/subu alu_src=0; ori ext=0; lw/sw/beq ext=1; lui alu_op=011.
//     beq: alu_op=sub, pc_we=zero, pc_src=01 -> FETCH. R/ori/lui -> WB. lw/sw alu_op=add -> MEM.
//   MEM: mem_req=1 iord=1, mem_we=1 for sw; held stable while waiting. On mem_ready: sw -> FETCH, lw -> WB.
//   WB (1 cycle): reg_we=1; R: reg_dst=01 wd_src=00; ori/lui: reg_dst=00 wd_src=00; lw: reg_dst=00 wd_src=01 -> FETCH.
//   Latency (mem_ready=1 immediately): j/jal/jr 2, beq 3, sw 4, R/ori/lui 4, lw 5 cycles.
//   instr_cnt +1 on the last cycle of every legal instruction (the cycle that moves to FETCH). Wraps mod 2^CNT_W.
//   wait_cnt: clears on entry to FETCH/MEM; +1 each cycle there with mem_ready=0.
//     Reaching MAX_WAIT with mem_ready still 0 -> ERR. mem_ready in that same cycle wins (normal completion).
//   ERR: err=1, all strobes/mem_req=0, no exit except reset. instr_cnt frozen.
//   Reset mid-instruction: abandons it immediately; strobes drop asynchronously; nothing retires.
// TESTING
//   1. Program ori $1,$0,5; addu $2,$1,$1; mem_ready tied 1 -> $2=10, instr_cnt=2 after 8 cycles.
//   2. sw $2,0($0); lw $3,0($0) with mem_ready delayed 3 cycles per request -> mem_req/mem_we held, $3=10.
//   3. beq taken (zero=1) and not taken -> pc_we only when zero=1; PC = target vs PC+4; 3 cycles each.
//   4. jal 0x0C00 then jr $31 -> $31 = return PC, PC returns; each 2 cycles, instr_cnt +2.
//   5. mem_ready held 0 in FETCH -> ERR after MAX_WAIT=15 cycles, err=1, strobes 0; release reset -> FETCH.
//   6. reset pulsed low in MEM of sw -> mem_we drops same cycle, state=FETCH, instr_cnt=0; illegal op -> no count.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// mips_mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/ERR).
// Drives datapath selects and strobes, handshakes with memory, counts retired instructions.
module mips_mc_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_src,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             ext_op,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd7
    } state_e;

    state_e            cur_st;
    state_e            nxt_st;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

    assign is_rtype = (op == 6'h00);
    assign is_addu  = is_rtype && (funct == 6'h21);
    assign is_subu  = is_rtype && (funct == 6'h23);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_ori   = (op == 6'h0D);
    assign is_lui   = (op == 6'h0F);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j | is_jal;

    always_comb begin
        nxt_st  = cur_st;
        retire  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        iord    = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 2'b00;
        reg_we  = 1'b0;
        reg_dst = 2'b00;
        wd_src  = 2'b00;
        alu_src = 1'b0;
        alu_op  = 3'b000;
        ext_op  = 1'b0;
        err     = 1'b0;

        // ALU controls stay valid through MEM/WB so the address/result is stable
        if (cur_st == EXEC || cur_st == MEM || cur_st == WB) begin
            alu_src = !(is_rtype || is_beq);
            ext_op  = is_lw || is_sw || is_beq;
            if (is_subu || is_beq)
                alu_op = 3'b001;
            else if (is_ori)
                alu_op = 3'b010;
            else if (is_lui)
                alu_op = 3'b011;
        end

        case (cur_st)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    nxt_st = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt_st = ERR;
                end
            end
            DECODE: begin
                if (is_j || is_jal) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                end
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'b10;
                    wd_src  = 2'b10;
                end
                if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b11;
                end
                if (is_j || is_jal || is_jr) begin
                    retire = 1'b1;
                    nxt_st = FETCH;
                end else if (is_legal) begin
                    nxt_st = EXEC;
                end else begin
                    nxt_st = FETCH;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    pc_we  = zero;
                    pc_src = 2'b01;
                    retire = 1'b1;
                    nxt_st = FETCH;
                end else if (is_lw || is_sw) begin
                    nxt_st = MEM;
                end else begin
                    nxt_st = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire = 1'b1;
                        nxt_st = FETCH;
                    end else begin
                        nxt_st = WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt_st = ERR;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                reg_dst = is_rtype ? 2'b01 : 2'b00;
                wd_src  = is_lw ? 2'b01 : 2'b00;
                retire  = 1'b1;
                nxt_st  = FETCH;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                nxt_st = ERR;
            end
        endcase

        // Strobes must drop the instant reset asserts, not at the next edge
        if (!reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_st    <= FETCH;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            cur_st <= nxt_st;
            if (nxt_st != cur_st)
                wait_cnt <= '0;
            else if ((cur_st == FETCH || cur_st == MEM) && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign state = cur_st;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// tb_mips_mc_ctrl: randomized bench; expected per-cycle traces are built from
// each instruction's class and the memory delays chosen for it.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src, ext_op, err;
    logic [1:0]  pc_src, reg_dst, wd_src;
    logic [2:0]  alu_op, state;
    logic [31:0] instr_cnt;

    mips_mc_ctrl #(.CNT_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_src(wd_src), .alu_src(alu_src), .alu_op(alu_op),
        .ext_op(ext_op), .state(state), .err(err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4,
                   K_LW = 5, K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;
    localparam int TIMEOUT = 15;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 32'd0;

    logic       e_req, e_we, e_iord, e_irwe, e_pcwe, e_regwe, e_alu, e_ext_chk;
    logic       e_alusrc, e_ext, e_err;
    logic [1:0] e_pcsrc, e_regdst, e_wdsrc;
    logic [2:0] e_aluop, e_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clr(input logic [2:0] s);
        {e_req, e_we, e_iord, e_irwe, e_pcwe, e_regwe, e_alu, e_ext_chk} = '0;
        {e_alusrc, e_ext, e_err, e_pcsrc, e_regdst, e_wdsrc, e_aluop} = '0;
        e_state = s;
    endtask

    // Compare all outputs at the falling edge, then advance past the next rising edge.
    task automatic step(input string tag);
        logic [20:0] o, x, m;
        @(negedge clk);
        o = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_src,
             alu_src, alu_op, ext_op, state, err};
        x = {e_req, e_we, e_iord, e_irwe, e_pcwe, e_pcsrc, e_regwe, e_regdst, e_wdsrc,
             e_alusrc, e_aluop, e_ext, e_state, e_err};
        m = {1'b1, 1'b1, e_req, 1'b1, 1'b1, {2{e_pcwe}}, 1'b1, {2{e_regwe}}, {2{e_regwe}},
             e_alu, {3{e_alu}}, e_ext_chk, 3'b111, 1'b1};
        check(tag, 32'(o & m), 32'(x & m));
        @(posedge clk);
        #1;
    endtask

    task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (k)
            K_ADDU: begin o = 6'h00; f = 6'h21; end
            K_SUBU: begin o = 6'h00; f = 6'h23; end
            K_JR:   begin o = 6'h00; f = 6'h08; end
            K_ORI:  o = 6'h0D;
            K_LUI:  o = 6'h0F;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2B;
            K_BEQ:  o = 6'h04;
            K_J:    o = 6'h02;
            K_JAL:  o = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = 6'h00;
                    while (f == 6'h21 || f == 6'h23 || f == 6'h08) f = 6'($urandom);
                end else begin
                    o = 6'h00;
                    while (o == 6'h00 || o == 6'h0D || o == 6'h0F || o == 6'h23 ||
                           o == 6'h2B || o == 6'h04 || o == 6'h02 || o == 6'h03)
                        o = 6'($urandom);
                end
            end
        endcase
    endtask

    // Hold mem_ready low for d cycles; reports timeout if the limit is reached first.
    task automatic mem_wait(input logic [2:0] s, input logic we, input logic io,
                            input int d, output bit to);
        to = 1'b0;
        for (int i = 0; i < d && i < TIMEOUT; i++) begin
            mem_ready = 1'b0;
            clr(s); e_req = 1'b1; e_we = we; e_iord = io;
            step("wait");
        end
        if (d >= TIMEOUT) to = 1'b1;
    endtask

    task automatic enter_reset();
        reset = 1'b0;
        #1;
        check("rst_async", {29'd0, mem_req, mem_we, ir_we | pc_we | reg_we}, 32'd0);
        clr(3'd0);
        step("in_reset");
        exp_cnt = 32'd0;
        check("rst_cnt", instr_cnt, exp_cnt);
        reset = 1'b1;
    endtask

    task automatic err_hold();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            clr(3'd7); e_err = 1'b1;
            step("err");
        end
        check("err_cnt_frozen", instr_cnt, exp_cnt);
        enter_reset();
    endtask

    task automatic do_instr(input int k, input logic zr, input int fd, input int md, input bit rmid);
        logic [5:0] o, f;
        bit         to;
        check("cnt", instr_cnt, exp_cnt);
        encode(k, o, f);
        op = o; funct = f; zero = zr;

        mem_wait(3'd0, 1'b0, 1'b0, fd, to);
        if (to) begin err_hold(); return; end
        mem_ready = 1'b1;
        clr(3'd0); e_req = 1'b1; e_irwe = 1'b1; e_pcwe = 1'b1; e_pcsrc = 2'b00;
        step("fetch");

        mem_ready = 1'($urandom);
        clr(3'd1);
        if (k == K_J || k == K_JAL) begin e_pcwe = 1'b1; e_pcsrc = 2'b10; end
        if (k == K_JAL) begin e_regwe = 1'b1; e_regdst = 2'b10; e_wdsrc = 2'b10; end
        if (k == K_JR) begin e_pcwe = 1'b1; e_pcsrc = 2'b11; end
        step("decode");
        if (k == K_J || k == K_JAL || k == K_JR) begin exp_cnt++; return; end
        if (k == K_ILL) return;

        mem_ready = 1'($urandom);
        clr(3'd2); e_alu = 1'b1;
        e_alusrc  = !(k == K_ADDU || k == K_SUBU || k == K_BEQ);
        e_aluop   = (k == K_SUBU || k == K_BEQ) ? 3'd1 : (k == K_ORI) ? 3'd2 :
                    (k == K_LUI) ? 3'd3 : 3'd0;
        e_ext_chk = (k == K_ORI || k == K_LW || k == K_SW || k == K_BEQ);
        e_ext     = (k != K_ORI);
        if (k == K_BEQ) begin e_pcwe = zr; e_pcsrc = 2'b01; end
        step("exec");
        if (k == K_BEQ) begin exp_cnt++; return; end

        if (k == K_LW || k == K_SW) begin
            mem_wait(3'd3, k == K_SW, 1'b1, md, to);
            if (to) begin err_hold(); return; end
            if (rmid) begin enter_reset(); return; end
            mem_ready = 1'b1;
            clr(3'd3); e_req = 1'b1; e_we = (k == K_SW); e_iord = 1'b1;
            step("mem");
            if (k == K_SW) begin exp_cnt++; return; end
        end

        mem_ready = 1'($urandom);
        clr(3'd4); e_regwe = 1'b1;
        e_regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
        e_wdsrc  = (k == K_LW) ? 2'b01 : 2'b00;
        step("wb");
        exp_cnt++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, fd, md;
        #1;
        clr(3'd0);
        step("reset");
        step("reset");
        check("cnt_reset", instr_cnt, 32'd0);
        reset = 1'b1;

        do_instr(K_ORI, 1'b0, 0, 0, 1'b0);
        do_instr(K_ADDU, 1'b0, 0, 0, 1'b0);
        do_instr(K_SW, 1'b0, 3, 3, 1'b0);
        do_instr(K_LW, 1'b0, 3, 3, 1'b0);
        do_instr(K_BEQ, 1'b1, 0, 0, 1'b0);
        do_instr(K_BEQ, 1'b0, 0, 0, 1'b0);
        do_instr(K_JAL, 1'b0, 0, 0, 1'b0);
        do_instr(K_JR, 1'b0, 0, 0, 1'b0);
        do_instr(K_J, 1'b0, 1, 0, 1'b0);
        do_instr(K_SUBU, 1'b0, 0, 0, 1'b0);
        do_instr(K_LUI, 1'b0, 0, 0, 1'b0);
        do_instr(K_ILL, 1'b0, 0, 0, 1'b0);
        do_instr(K_ILL, 1'b0, 2, 0, 1'b0);
        do_instr(K_SW, 1'b0, 14, 14, 1'b0);
        do_instr(K_LW, 1'b0, 0, 14, 1'b0);

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 10);
            fd = ($urandom_range(0, 15) == 0) ? 14 : $urandom_range(0, 3);
            md = ($urandom_range(0, 15) == 0) ? 14 : $urandom_range(0, 3);
            do_instr(k, 1'($urandom), fd, md, 1'b0);
        end

        do_instr(K_SW, 1'b0, 0, 2, 1'b1);
        do_instr(K_ADDU, 1'b0, 0, 0, 1'b0);
        do_instr(K_ORI, 1'b0, 15, 0, 1'b0);
        do_instr(K_J, 1'b0, 0, 0, 1'b0);
        do_instr(K_LW, 1'b0, 0, 20, 1'b0);
        do_instr(K_BEQ, 1'b1, 0, 0, 1'b0);
        check("cnt_final", instr_cnt, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
